// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - key load and round-key stream signals of the AES-128 key schedule
interface aes_key_expand_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         dec_mode;
  logic         load_ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         done;

  modport master (
    output key_load, key_in, dec_mode, rk_ready,
    input  load_ready, rk_valid, rk_data, rk_idx, done
  );

  modport slave (
    input  key_load, key_in, dec_mode, rk_ready,
    output load_ready, rk_valid, rk_data, rk_idx, done
  );
endinterface

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - AES-128 key schedule: expands one key per cycle into an 11-entry buffer,
// then streams the round keys in ascending (enc) or descending (dec) order
module aes_key_expand #(
  parameter int NR     = 10,
  parameter int KEY_SZ = 128
) (
  input logic             clk,
  input logic             reset,
  aes_key_expand_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          round_q, round_d;
  logic [3:0]          ptr_q, ptr_d;
  logic                dec_q, dec_d;
  logic                rk_valid_q, rk_valid_d;
  logic [KEY_SZ-1:0]   rk_data_q, rk_data_d;
  logic [3:0]          rk_idx_q, rk_idx_d;
  logic                done_q, done_d;
  logic [KEY_SZ-1:0]   buf_q [0:NR];
  logic [KEY_SZ-1:0]   buf_d [0:NR];

  logic [3:0]          round_nx, ptr_nx, last_ptr;
  logic [KEY_SZ-1:0]   prev_w;
  logic [31:0]         t_w, nw0, nw1, nw2, nw3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, sq;
    y  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      y  = gf_mul(y, sq);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    ptr_d      = ptr_q;
    dec_d      = dec_q;
    rk_valid_d = rk_valid_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    done_d     = 1'b0;
    buf_d      = buf_q;

    // One round step on the previous buffer entry; only the EXPAND state commits it
    round_nx = round_q + 4'd1;
    prev_w   = buf_q[round_q];
    t_w      = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon(round_nx), 24'h0};
    nw0      = prev_w[127:96] ^ t_w;
    nw1      = prev_w[95:64]  ^ nw0;
    nw2      = prev_w[63:32]  ^ nw1;
    nw3      = prev_w[31:0]   ^ nw2;

    last_ptr = dec_q ? 4'd0 : 4'(NR);
    ptr_nx   = dec_q ? (ptr_q - 4'd1) : (ptr_q + 4'd1);

    case (state_q)
      IDLE: begin
        if (bus.key_load) begin
          buf_d[0] = bus.key_in;
          dec_d    = bus.dec_mode;
          round_d  = 4'd0;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        buf_d[round_nx] = {nw0, nw1, nw2, nw3};
        round_d         = round_nx;
        if (round_nx == 4'(NR)) begin
          state_d = OUT;
          ptr_d   = dec_q ? 4'(NR) : 4'd0;
        end
      end
      OUT: begin
        // Output registers are primed one cycle after entering OUT, then advance per transfer
        if (!rk_valid_q) begin
          rk_valid_d = 1'b1;
          rk_data_d  = buf_q[ptr_q];
          rk_idx_d   = ptr_q;
        end else if (bus.rk_ready) begin
          if (ptr_q == last_ptr) begin
            state_d    = IDLE;
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            ptr_d     = ptr_nx;
            rk_data_d = buf_q[ptr_nx];
            rk_idx_d  = ptr_nx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      round_q    <= 4'd0;
      ptr_q      <= 4'd0;
      dec_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      ptr_q      <= ptr_d;
      dec_q      <= dec_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.rk_valid   = rk_valid_q;
  assign bus.rk_data    = rk_data_q;
  assign bus.rk_idx     = rk_idx_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed bench for aes_key_expand using FIPS-197 and all-zero key vectors
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic reset;

  aes_key_expand_if bus ();

  aes_key_expand #(.NR(10), .KEY_SZ(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] fips_rk   [0:10];
  logic [127:0] exp_rk    [0:10];
  bit           exp_known [0:10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_exp_fips();
    for (int i = 0; i <= 10; i++) begin
      exp_rk[i]    = fips_rk[i];
      exp_known[i] = 1'b1;
    end
  endtask

  task automatic set_exp_zero();
    for (int i = 0; i <= 10; i++) begin
      exp_rk[i]    = 128'h0;
      exp_known[i] = 1'b0;
    end
    exp_rk[0]  = 128'h0;
    exp_rk[1]  = 128'h62636363626363636263636362636363;
    exp_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    exp_known[0]  = 1'b1;
    exp_known[1]  = 1'b1;
    exp_known[10] = 1'b1;
  endtask

  task automatic load_key(input logic [127:0] k, input bit dec);
    int c;
    c = 0;
    while (!bus.load_ready && c < 100) begin
      tick();
      c++;
    end
    chk("load_ready_wait", 128'(bus.load_ready), 128'(1));
    bus.key_load = 1'b1;
    bus.key_in   = k;
    bus.dec_mode = dec;
    tick();
    bus.key_load = 1'b0;
  endtask

  task automatic wait_first(input int exp_c);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!bus.rk_valid && c < 40);
    chk("first_valid_latency", 128'(c), 128'(exp_c));
  endtask

  // mode 0: rk_ready always high; mode 1: random ready with a 5-cycle stall at the 5th key
  task automatic run_out(input bit dec, input int mode, input bit inject, input int stop_after);
    int   n, cyc, stall_left, exp_i;
    logic r;
    n = 0;
    cyc = 0;
    stall_left = 5;
    while (n < stop_after && cyc < 300) begin
      exp_i = dec ? (10 - n) : n;
      chk("rk_valid_hold", 128'(bus.rk_valid), 128'(1));
      chk("rk_idx", 128'(bus.rk_idx), 128'(exp_i));
      if (exp_known[exp_i]) chk("rk_data", bus.rk_data, exp_rk[exp_i]);
      if (mode == 0) r = 1'b1;
      else if (n == 4 && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else r = 1'($urandom_range(0, 1));
      if (inject) begin
        bus.key_load = (n == 3);
        bus.key_in   = ZERO_KEY;
      end
      bus.rk_ready = r;
      tick();
      cyc++;
      if (r) n++;
    end
    if (cyc >= 300) chk("run_out_timeout", 128'(n), 128'(stop_after));
    if (inject) bus.key_load = 1'b0;
  endtask

  task automatic finish_check();
    chk("end_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("end_done", 128'(bus.done), 128'(1));
    chk("end_load_ready", 128'(bus.load_ready), 128'(1));
  endtask

  task automatic abort_check();
    chk("abort_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("abort_load_ready", 128'(bus.load_ready), 128'(1));
    chk("abort_done", 128'(bus.done), 128'(0));
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset        = 1'b1;
    bus.key_load = 1'b0;
    bus.key_in   = ZERO_KEY;
    bus.dec_mode = 1'b0;
    bus.rk_ready = 1'b0;
    tick();
    tick();
    chk("rst_load_ready", 128'(bus.load_ready), 128'(1));
    chk("rst_rk_valid", 128'(bus.rk_valid), 128'(0));
    chk("rst_rk_data", bus.rk_data, 128'h0);
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    reset = 1'b0;
    tick();

    // FIPS-197 encryption order
    set_exp_fips();
    load_key(FIPS_KEY, 1'b0);
    wait_first(11);
    run_out(1'b0, 0, 1'b0, 11);
    finish_check();
    tick();
    chk("done_single_pulse", 128'(bus.done), 128'(0));

    // Decryption order
    load_key(FIPS_KEY, 1'b1);
    wait_first(11);
    run_out(1'b1, 0, 1'b0, 11);
    finish_check();
    tick();

    // Backpressure
    load_key(FIPS_KEY, 1'b0);
    wait_first(11);
    run_out(1'b0, 1, 1'b0, 11);
    finish_check();
    tick();
    chk("bp_done_low", 128'(bus.done), 128'(0));

    // Loads during EXPAND and OUT are ignored
    load_key(FIPS_KEY, 1'b0);
    tick();
    tick();
    tick();
    bus.key_load = 1'b1;
    bus.key_in   = ZERO_KEY;
    chk("expand_load_ready", 128'(bus.load_ready), 128'(0));
    tick();
    bus.key_load = 1'b0;
    wait_first(7);
    run_out(1'b0, 0, 1'b1, 11);
    finish_check();
    tick();

    // All-zero key loaded from IDLE
    set_exp_zero();
    load_key(ZERO_KEY, 1'b0);
    wait_first(11);
    run_out(1'b0, 0, 1'b0, 11);
    finish_check();
    tick();

    // Reset at EXPAND cycle 4, then a fresh load
    set_exp_fips();
    load_key(FIPS_KEY, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    abort_check();
    load_key(FIPS_KEY, 1'b0);
    wait_first(11);
    run_out(1'b0, 0, 1'b0, 11);
    finish_check();
    tick();

    // Reset while presenting rk6, then a fresh decryption load
    load_key(FIPS_KEY, 1'b0);
    wait_first(11);
    run_out(1'b0, 0, 1'b0, 6);
    bus.rk_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    abort_check();
    chk("abort_rk_idx", 128'(bus.rk_idx), 128'(0));
    chk("abort_rk_data", bus.rk_data, 128'h0);
    load_key(FIPS_KEY, 1'b1);
    wait_first(11);
    run_out(1'b1, 0, 1'b0, 11);
    finish_check();
    tick();

    // Back-to-back with key_load held high
    bus.key_load = 1'b1;
    bus.key_in   = FIPS_KEY;
    bus.dec_mode = 1'b0;
    tick();
    wait_first(11);
    bus.key_in = ZERO_KEY;
    run_out(1'b0, 0, 1'b0, 11);
    finish_check();
    tick();
    bus.key_load = 1'b0;
    chk("b2b_done_low", 128'(bus.done), 128'(0));
    chk("b2b_no_spurious_valid", 128'(bus.rk_valid), 128'(0));
    set_exp_zero();
    wait_first(11);
    run_out(1'b0, 0, 1'b0, 11);
    finish_check();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
